// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: constants, fetch FSM
// state encoding and the IF/ID register layout.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter and outstanding-request address for the fetch stage,
// with the next-PC mux (increment, hazard rewind, branch redirect).
module fetch_pc
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        advance_i,
  input  logic        rewind_i,
  input  logic [15:0] pc_offset_i,
  input  logic        req_done_i,
  output logic [31:0] pc_o,
  output logic [31:0] req_addr_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] rewind_amt;

  assign rewind_amt = rewind_i ? {16'h0000, pc_offset_i} : 32'h0000_0000;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = word_align(redirect_pc_i);
    end else if (advance_i) begin
      pc_d = word_align(pc_q + PC_INCR - rewind_amt);
    end
  end

  // An in-flight request keeps its address until the memory answers it.
  assign req_addr_d = req_done_i ? pc_d : req_addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= word_align(RESET_PC);
      req_addr_q <= word_align(RESET_PC);
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign pc_o       = pc_q;
  assign req_addr_o = req_addr_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: fetch FSM, imem handshake and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bubble_i,
  input  logic [15:0] pc_offset_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_plus4_o,
`ifdef FETCH_PERF_CNT_EN
  output logic        id_valid_o,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o
`else
  output logic        id_valid_o
`endif
);

  // state | meaning
  // BOOT  | post-reset idle cycle, no request
  // FETCH | request at req_addr, accept on imem_ready
  // FLUSH | redirect pending, draining stale outstanding request

  fetch_state_t state_q, state_d;
  if_id_t       if_id_q, if_id_d;
  logic         accept;
  logic         req_done;
  logic [31:0]  pc;
  logic [31:0]  req_addr;

  assign accept   = (state_q == FETCH) && imem_ready_i;
  assign req_done = (state_q == BOOT) || imem_ready_i;

  fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (branch_taken_i),
    .redirect_pc_i (branch_target_i),
    .advance_i     (accept),
    .rewind_i      (bubble_i),
    .pc_offset_i   (pc_offset_i),
    .req_done_i    (req_done),
    .pc_o          (pc),
    .req_addr_o    (req_addr)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (branch_taken_i && !imem_ready_i) state_d = FLUSH;
      FLUSH:   if (imem_ready_i) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    if_id_d = if_id_q;
    if (branch_taken_i) begin
      if_id_d = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
    end else if (accept && !bubble_i) begin
      if_id_d = '{instr: imem_rdata_i, pc_plus4: pc + PC_INCR, valid: 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      if_id_q <= '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
    end else begin
      state_q <= state_d;
      if_id_q <= if_id_d;
    end
  end

  assign imem_req_o    = (state_q != BOOT);
  assign imem_addr_o   = req_addr;
  assign id_instr_o    = if_id_q.instr;
  assign id_pc_plus4_o = if_id_q.pc_plus4;
  assign id_valid_o    = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  assign stall_cnt_d = (bubble_i && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  assign flush_cnt_d = (branch_taken_i && (flush_cnt_q != 32'hFFFF_FFFF)) ? flush_cnt_q + 32'd1 : flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (default and wrapping RESET_PC)
// driven by the same stimulus; memory returns addr ^ 32'hC000_0000.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        bubble;
  logic [15:0] pc_offset;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ready;

  logic        req_a, req_b;
  logic [31:0] addr_a, addr_b;
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] instr_a, instr_b;
  logic [31:0] pc4_a, pc4_b;
  logic        valid_a, valid_b;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_a, flush_a, stall_b, flush_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rdata_a = addr_a ^ 32'hC000_0000;
  assign rdata_b = addr_b ^ 32'hC000_0000;

  fetch_stage u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .bubble_i        (bubble),
    .pc_offset_i     (pc_offset),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .imem_req_o      (req_a),
    .imem_addr_o     (addr_a),
    .imem_ready_i    (imem_ready),
    .imem_rdata_i    (rdata_a),
    .id_instr_o      (instr_a),
    .id_pc_plus4_o   (pc4_a),
`ifdef FETCH_PERF_CNT_EN
    .id_valid_o      (valid_a),
    .perf_stall_cnt_o(stall_a),
    .perf_flush_cnt_o(flush_a)
`else
    .id_valid_o      (valid_a)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk_i           (clk),
    .rst_i           (rst),
    .bubble_i        (bubble),
    .pc_offset_i     (pc_offset),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .imem_req_o      (req_b),
    .imem_addr_o     (addr_b),
    .imem_ready_i    (imem_ready),
    .imem_rdata_i    (rdata_b),
    .id_instr_o      (instr_b),
    .id_pc_plus4_o   (pc4_b),
`ifdef FETCH_PERF_CNT_EN
    .id_valid_o      (valid_b),
    .perf_stall_cnt_o(stall_b),
    .perf_flush_cnt_o(flush_b)
`else
    .id_valid_o      (valid_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; bubble = 1'b0; pc_offset = 16'd0;
    branch_taken = 1'b0; branch_target = 32'h0; imem_ready = 1'b1;
    tick(); tick();
    chk("rst_req",    {31'b0, req_a},   32'd0);
    chk("rst_instr",  instr_a,          32'h0);
    chk("rst_pc4",    pc4_a,            32'h0);
    chk("rst_valid",  {31'b0, valid_a}, 32'd0);
    chk("rst_addr",   addr_a,           32'h0);
    chk("rst_addr_w", addr_b,           32'hFFFF_FFF8);
    rst = 1'b0;
    #1;
    chk("boot_req",   {31'b0, req_a},   32'd0);

    tick();
    chk("c1_req",     {31'b0, req_a},   32'd1);
    chk("c1_addr",    addr_a,           32'h0);
    chk("c1_addr_w",  addr_b,           32'hFFFF_FFF8);
    tick();
    chk("c2_pc4",     pc4_a,            32'd4);
    chk("c2_instr",   instr_a,          32'hC000_0000);
    chk("c2_valid",   {31'b0, valid_a}, 32'd1);
    chk("c2_addr",    addr_a,           32'd4);
    chk("c2_addr_w",  addr_b,           32'hFFFF_FFFC);
    tick();
    chk("c3_pc4",     pc4_a,            32'd8);
    chk("c3_instr",   instr_a,          32'hC000_0004);
    chk("c3_addr",    addr_a,           32'd8);
    chk("c3_addr_w",  addr_b,           32'h0);
    chk("c3_pc4_w",   pc4_b,            32'h0);
    chk("c3_instr_w", instr_b,          32'h3FFF_FFFC);

    // load-use bubble while word 8 is being accepted
    bubble = 1'b1; pc_offset = 16'd4;
    tick();
    chk("bub_pc4",    pc4_a,            32'd8);
    chk("bub_instr",  instr_a,          32'hC000_0004);
    chk("bub_addr",   addr_a,           32'd8);
    bubble = 1'b0; pc_offset = 16'd0;
    tick();
    chk("rf_pc4",     pc4_a,            32'd12);
    chk("rf_instr",   instr_a,          32'hC000_0008);
    chk("rf_addr",    addr_a,           32'd12);

    // zero-wait branch, unaligned target
    branch_taken = 1'b1; branch_target = 32'h0000_0103;
    tick();
    chk("br_valid",   {31'b0, valid_a}, 32'd0);
    chk("br_instr",   instr_a,          32'h0);
    chk("br_addr",    addr_a,           32'h100);
    branch_taken = 1'b0;
    tick();
    chk("br_tgt_ins", instr_a,          32'hC000_0100);
    chk("br_tgt_pc4", pc4_a,            32'h104);
    chk("br_tgt_val", {31'b0, valid_a}, 32'd1);

    // branch while request to 0x104 is stalled for three cycles
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    chk("fl0_addr",   addr_a,           32'h104);
    chk("fl0_req",    {31'b0, req_a},   32'd1);
    chk("fl0_valid",  {31'b0, valid_a}, 32'd0);
    branch_taken = 1'b0;
    tick();
    chk("fl1_addr",   addr_a,           32'h104);
    tick();
    chk("fl2_addr",   addr_a,           32'h104);
    imem_ready = 1'b1;
    tick();
    chk("fl3_addr",   addr_a,           32'h200);
    chk("fl3_valid",  {31'b0, valid_a}, 32'd0);
    chk("fl3_instr",  instr_a,          32'h0);
    tick();
    chk("fl4_instr",  instr_a,          32'hC000_0200);
    chk("fl4_pc4",    pc4_a,            32'h204);

    // branch and bubble together: branch wins
    branch_taken = 1'b1; branch_target = 32'h300; bubble = 1'b1; pc_offset = 16'd4;
    tick();
    chk("bb_valid",   {31'b0, valid_a}, 32'd0);
    chk("bb_addr",    addr_a,           32'h300);
    branch_taken = 1'b0; bubble = 1'b0; pc_offset = 16'd0;
    tick();
    chk("bb_pc4",     pc4_a,            32'h304);

    // bubble without accept holds everything
    imem_ready = 1'b0; bubble = 1'b1; pc_offset = 16'd4;
    repeat (5) tick();
    chk("hold_pc4",   pc4_a,            32'h304);
    chk("hold_instr", instr_a,          32'hC000_0300);
    chk("hold_addr",  addr_a,           32'h304);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", stall_a,          32'd7);
    chk("perf_flush", flush_a,          32'd3);
`endif

    // reset with a request outstanding
    bubble = 1'b0; pc_offset = 16'd0; rst = 1'b1;
    tick();
    chk("mr_req",     {31'b0, req_a},   32'd0);
    chk("mr_valid",   {31'b0, valid_a}, 32'd0);
    chk("mr_addr",    addr_a,           32'h0);
    rst = 1'b0; imem_ready = 1'b1; bubble = 1'b1; pc_offset = 16'd4;
    repeat (5) tick();
    chk("b5_addr",    addr_a,           32'h0);
    chk("b5_valid",   {31'b0, valid_a}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("b5_stall",   stall_a,          32'd5);
    chk("b5_flush",   flush_a,          32'd0);
`endif
    bubble = 1'b0; pc_offset = 16'd0;
    tick();
    chk("b5_pc4",     pc4_a,            32'd4);
    chk("b5_val1",    {31'b0, valid_a}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory request handshake and holds the IF/ID pipeline register. It consumes the `bubble`/`pc_offset` pair from the hazard-detection unit and the taken-branch redirect from EX. It feeds `id_instr`/`id_pc_plus4` to decode and the register-field extraction that drives the hazard unit's `rs`/`rt`.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] ignored.
- `clk`  input  1  pipeline clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `bubble`  input  1  load-use stall request from hazard unit.
- `pc_offset`  input  16  PC rewind amount from hazard unit, zero-extended; 0 when `bubble`=0.
- `branch_taken`  input  1  one-cycle redirect pulse from EX.
- `branch_target`  input  32  redirect address; bits [1:0] forced to 0.
- `imem_req`  output  1  fetch request valid.
- `imem_addr`  output  32  word-aligned fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready`  input  1  response strobe; `imem_rdata` valid this cycle. May assert in the same cycle as `imem_req`.
- `imem_rdata`  input  32  fetched instruction.
- `id_instr`  output  32  IF/ID instruction; NOP (32'h0) when invalid.
- `id_pc_plus4`  output  32  IF/ID PC+4 of `id_instr`.
- `id_valid`  output  1  IF/ID slot holds a real instruction.

## Operation
- State machine states:
  - BOOT: entered on reset. `imem_req`=0 for exactly one cycle, then FETCH.
  - FETCH: `imem_req`=1, `imem_addr`=`req_addr`.
  - FLUSH: a redirect arrived while a request was outstanding. `imem_req` stays 1 with the old `req_addr` until `imem_ready`. The returning word is discarded, then the state moves to FETCH at the redirected PC.
- Accept event: FETCH and `imem_ready`=1.
- Priority per cycle: `rst` > `branch_taken` > `bubble` > normal accept.
- Normal accept (`bubble`=0, no branch):
  - IF/ID <= {`imem_rdata`, `pc`+4, valid=1}.
  - `pc` <= `pc`+4.
  - `req_addr` <= `pc`+4.
- Bubble on accept:
  - IF/ID holds.
  - `pc` <= `pc` + 4 − `pc_offset`. With `pc_offset`=4 the same word is refetched.
  - Fetched word discarded.
- Bubble without accept: IF/ID and `pc` hold.
- Branch:
  - `pc` <= {`branch_target`[31:2], 2'b00}.
  - IF/ID <= {NOP, 0, valid=0}.
  - If FETCH and `imem_ready`=1: data discarded, `req_addr` <= target, stay FETCH.
  - If FETCH and `imem_ready`=0: go FLUSH.
  - If already FLUSH: latest target wins.
- No accept and no branch: IF/ID holds; `id_valid` unchanged.
- Arithmetic: all PC math modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: `pc`=`req_addr`=`RESET_PC`&~3, `imem_req`=0, `id_instr`=0, `id_pc_plus4`=0, `id_valid`=0, state BOOT.
- First request asserted 1 cycle after `rst` deasserts.
- With zero-wait memory (`imem_ready` tied high), throughput is 1 instruction/cycle.
- Fetch-to-IF/ID latency is 1 cycle after the accept edge.
- Branch penalty: the first target instruction reaches IF/ID no earlier than 2 cycles after the `branch_taken` edge, plus remaining wait on any outstanding request.
- `rst` mid-FLUSH or mid-request: the request is abandoned immediately, `imem_req`=0 next cycle.
- `imem_ready` while `imem_req`=0 is ignored.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds two 32-bit outputs.
  - `perf_stall_cnt`: counts cycles with `bubble`=1.
  - `perf_flush_cnt`: counts `branch_taken` pulses.
  - Both saturate at 32'hFFFF_FFFF and are cleared by `rst`.
- `FETCH_PERF_CNT_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package `mips_pkg`:
  - `NOP_INSTR` (32'h0).
  - `PC_INCR` (4).
  - `fetch_state_t` enum {BOOT, FETCH, FLUSH}.
  - `if_id_t` struct {instr, pc_plus4, valid}.
- One sub-module `fetch_pc`: holds `pc`/`req_addr` and the next-PC mux (increment, rewind, redirect, alignment).
- FSM and IF/ID register live in `fetch_stage`.

## Test plan
- Reset, memory zero-wait, `imem_rdata`=addr: cycle 1 `imem_addr`=0. IF/ID then shows pc_plus4 = 4, 8, 12 on consecutive cycles with `id_valid`=1.
- `bubble`=1, `pc_offset`=4 for one cycle at `pc`=8: IF/ID holds the instr@4. Address 8 is refetched next cycle, and instr@8 enters IF/ID one cycle late.
- `branch_taken` with target 32'h0000_0103, zero-wait: `id_valid`=0 next cycle and `imem_addr`=32'h100. Instr@0x100 is in IF/ID the following cycle.
- `imem_ready` held low 3 cycles, `branch_taken` in the first: `imem_addr` stays at the old address until ready. That word is never in IF/ID; the next request address is the target.
- `branch_taken` and `bubble` in the same cycle: branch wins, `id_valid`=0, `pc`=target.
- `RESET_PC`=32'hFFFF_FFF8: fetches FFFF_FFF8, FFFF_FFFC, then 0. With `FETCH_PERF_CNT_EN`, 5 bubble cycles give `perf_stall_cnt`=5.
